// File: rtl/fetch_pkg.sv
// ============================================================================
// Module : fetch_pkg
// Brief  : Shared types and constants for the instruction fetch unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  localparam logic [31:0] C_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] C_PC_INC   = 32'd4;

endpackage

`default_nettype wire

// File: rtl/inst_fetch.sv
// ============================================================================
// Module : inst_fetch
// Brief  : Single-outstanding-request instruction fetch with a one-entry
//          hold buffer and redirect/drain handling.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module inst_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = C_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst_code,
  output logic [31:0] inst_pc
);

  fetch_state_t r_state, w_state_nxt;
  logic [31:0]  r_fetch_pc, w_fetch_pc_nxt;
  logic [31:0]  r_redir_pc, w_redir_pc_nxt;
  logic [31:0]  r_hold_code, w_hold_code_nxt;
  logic [31:0]  r_hold_pc, w_hold_pc_nxt;
  logic         r_inst_valid, w_inst_valid_nxt;
  logic [31:0]  r_inst_code, w_inst_code_nxt;
  logic [31:0]  r_inst_pc, w_inst_pc_nxt;

  logic [31:0]  w_redirect_pc;
  logic [31:0]  w_pc_plus;
  logic         w_consume;

  assign w_redirect_pc = {redirect_pc[31:2], 2'b00};
  assign w_pc_plus     = r_fetch_pc + C_PC_INC;
  assign w_consume     = r_inst_valid & ~stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= FETCH;
      r_fetch_pc   <= RESET_PC;
      r_redir_pc   <= '0;
      r_hold_code  <= '0;
      r_hold_pc    <= '0;
      r_inst_valid <= 1'b0;
      r_inst_code  <= '0;
      r_inst_pc    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_fetch_pc   <= w_fetch_pc_nxt;
      r_redir_pc   <= w_redir_pc_nxt;
      r_hold_code  <= w_hold_code_nxt;
      r_hold_pc    <= w_hold_pc_nxt;
      r_inst_valid <= w_inst_valid_nxt;
      r_inst_code  <= w_inst_code_nxt;
      r_inst_pc    <= w_inst_pc_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_fetch_pc_nxt   = r_fetch_pc;
    w_redir_pc_nxt   = r_redir_pc;
    w_hold_code_nxt  = r_hold_code;
    w_hold_pc_nxt    = r_hold_pc;
    w_inst_valid_nxt = r_inst_valid & ~w_consume;
    w_inst_code_nxt  = r_inst_code;
    w_inst_pc_nxt    = r_inst_pc;

    case (r_state)
      FETCH: begin
        if (redirect) begin
          w_inst_valid_nxt = 1'b0;
          if (imem_ack) begin
            w_fetch_pc_nxt = w_redirect_pc;
          end else begin
            // The old request is still in flight; wait for its ack first.
            w_redir_pc_nxt = w_redirect_pc;
            w_state_nxt    = DRAIN;
          end
        end else if (imem_ack) begin
          w_fetch_pc_nxt = w_pc_plus;
          if (!r_inst_valid || !stall) begin
            w_inst_valid_nxt = 1'b1;
            w_inst_code_nxt  = imem_rdata;
            w_inst_pc_nxt    = r_fetch_pc;
          end else begin
            w_hold_code_nxt = imem_rdata;
            w_hold_pc_nxt   = r_fetch_pc;
            w_state_nxt     = HOLD;
          end
        end
      end

      HOLD: begin
        if (redirect) begin
          w_inst_valid_nxt = 1'b0;
          w_hold_code_nxt  = '0;
          w_hold_pc_nxt    = '0;
          w_fetch_pc_nxt   = w_redirect_pc;
          w_state_nxt      = FETCH;
        end else if (!stall) begin
          w_inst_valid_nxt = 1'b1;
          w_inst_code_nxt  = r_hold_code;
          w_inst_pc_nxt    = r_hold_pc;
          w_state_nxt      = FETCH;
        end
      end

      DRAIN: begin
        if (redirect) begin
          w_inst_valid_nxt = 1'b0;
          w_redir_pc_nxt   = w_redirect_pc;
        end
        if (imem_ack) begin
          w_fetch_pc_nxt = redirect ? w_redirect_pc : r_redir_pc;
          w_state_nxt    = FETCH;
        end
      end

      default: begin
        w_state_nxt = FETCH;
      end
    endcase
  end

  assign imem_req   = (r_state != HOLD);
  assign imem_addr  = r_fetch_pc;
  assign inst_valid = r_inst_valid;
  assign inst_code  = r_inst_code;
  assign inst_pc    = r_inst_pc;

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch.sv
// ============================================================================
// Module : tb_inst_fetch
// Brief  : Directed self-checking bench for inst_fetch.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_inst_fetch;

  localparam logic [31:0] C_CODE_KEY = 32'h1234_5678;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        auto_ack;
  logic        man_ack;

  logic        req1, ack1, valid1;
  logic [31:0] addr1, rdata1, code1, pc1;
  logic        req2, ack2, valid2;
  logic [31:0] addr2, rdata2, code2, pc2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign ack1   = auto_ack ? req1 : man_ack;
  assign rdata1 = addr1 ^ C_CODE_KEY;
  assign ack2   = req2;
  assign rdata2 = addr2 ^ C_CODE_KEY;

  inst_fetch dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (req1),
    .imem_addr  (addr1),
    .imem_ack   (ack1),
    .imem_rdata (rdata1),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .inst_valid (valid1),
    .inst_code  (code1),
    .inst_pc    (pc1)
  );

  inst_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (req2),
    .imem_addr  (addr2),
    .imem_ack   (ack2),
    .imem_rdata (rdata2),
    .stall      (1'b0),
    .redirect   (1'b0),
    .redirect_pc(32'h0),
    .inst_valid (valid2),
    .inst_code  (code2),
    .inst_pc    (pc2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset       = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    auto_ack    = 1'b1;
    man_ack     = 1'b0;

    #3;
    chk("rst_valid", {31'b0, valid1}, 32'd0);
    chk("rst_code",  code1, 32'h0);
    chk("rst_pc",    pc1, 32'h0);
    chk("rst_addr",  addr1, 32'h0);
    chk("rst_req",   {31'b0, req1}, 32'd1);
    chk("rst_addr2", addr2, 32'hFFFF_FFF8);

    @(posedge clk);
    #1;
    reset = 1'b0;

    // zero-wait stream 0,4,8 and wrap on the second instance
    tick();
    chk("s0_valid", {31'b0, valid1}, 32'd1);
    chk("s0_pc",    pc1, 32'h0);
    chk("s0_code",  code1, 32'h1234_5678);
    chk("s0_addr",  addr1, 32'h4);
    chk("w0_pc",    pc2, 32'hFFFF_FFF8);
    chk("w0_code",  code2, 32'hEDCB_A980);
    chk("w0_addr",  addr2, 32'hFFFF_FFFC);
    tick();
    chk("s1_pc",    pc1, 32'h4);
    chk("s1_code",  code1, 32'h1234_567C);
    chk("w1_pc",    pc2, 32'hFFFF_FFFC);
    chk("w1_addr",  addr2, 32'h0);
    tick();
    chk("s2_pc",    pc1, 32'h8);
    chk("s2_code",  code1, 32'h1234_5670);
    chk("w2_pc",    pc2, 32'h0);

    // stall 3 cycles while pc 8 held and pc 12 acked
    stall = 1'b1;
    tick();
    chk("h0_req",   {31'b0, req1}, 32'd0);
    chk("h0_pc",    pc1, 32'h8);
    chk("h0_valid", {31'b0, valid1}, 32'd1);
    tick();
    chk("h1_req",   {31'b0, req1}, 32'd0);
    tick();
    chk("h2_pc",    pc1, 32'h8);
    chk("h2_req",   {31'b0, req1}, 32'd0);
    stall = 1'b0;
    auto_ack = 1'b0;
    tick();
    chk("h3_pc",    pc1, 32'hC);
    chk("h3_code",  code1, 32'h1234_5674);
    chk("h3_req",   {31'b0, req1}, 32'd1);
    chk("h3_addr",  addr1, 32'h10);

    // slow memory: redirect one cycle after the request to 16
    tick();
    chk("d0_valid", {31'b0, valid1}, 32'd0);
    redirect = 1'b1;
    redirect_pc = 32'h100;
    tick();
    chk("d1_addr",  addr1, 32'h10);
    chk("d1_req",   {31'b0, req1}, 32'd1);
    chk("d1_valid", {31'b0, valid1}, 32'd0);
    redirect = 1'b0;
    man_ack = 1'b1;
    tick();
    chk("d2_addr",  addr1, 32'h100);
    chk("d2_valid", {31'b0, valid1}, 32'd0);
    man_ack = 1'b0;
    tick();
    chk("d3_addr",  addr1, 32'h100);
    chk("d3_valid", {31'b0, valid1}, 32'd0);
    man_ack = 1'b1;
    tick();
    chk("d4_valid", {31'b0, valid1}, 32'd1);
    chk("d4_pc",    pc1, 32'h100);
    chk("d4_code",  code1, 32'h1234_5778);
    chk("d4_addr",  addr1, 32'h104);

    // redirect with same-cycle ack, unaligned target
    redirect = 1'b1;
    redirect_pc = 32'h203;
    tick();
    chk("r0_addr",  addr1, 32'h200);
    chk("r0_valid", {31'b0, valid1}, 32'd0);
    redirect = 1'b0;
    tick();
    chk("r1_pc",    pc1, 32'h200);
    chk("r1_code",  code1, 32'h1234_5478);

    // redirect while in HOLD
    stall = 1'b1;
    tick();
    chk("rh0_req",  {31'b0, req1}, 32'd0);
    redirect = 1'b1;
    redirect_pc = 32'h40;
    tick();
    chk("rh1_valid", {31'b0, valid1}, 32'd0);
    chk("rh1_addr",  addr1, 32'h40);
    chk("rh1_req",   {31'b0, req1}, 32'd1);

    // reset in the middle of DRAIN
    stall = 1'b0;
    man_ack = 1'b0;
    redirect_pc = 32'h300;
    tick();
    chk("rd0_addr", addr1, 32'h40);
    redirect = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    chk("rd1_valid", {31'b0, valid1}, 32'd0);
    chk("rd1_code",  code1, 32'h0);
    chk("rd1_pc",    pc1, 32'h0);
    chk("rd1_addr",  addr1, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    man_ack = 1'b1;
    tick();
    chk("rd2_valid", {31'b0, valid1}, 32'd1);
    chk("rd2_pc",    pc1, 32'h0);
    chk("rd2_code",  code1, 32'h1234_5678);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
